// File: rtl/shady_pong_pkg.sv
// Shared constants for the Shady Pong input path: button channel map and
// 25 MHz pixel-clock derived timing defaults.
package shady_pong_pkg;

  localparam int NUM_BTNS = 4;

  // Channel order on every button bus: {P1 up, P1 down, P2 up, P2 down}.
  localparam int BTN_P2_DOWN = 0;
  localparam int BTN_P2_UP   = 1;
  localparam int BTN_P1_DOWN = 2;
  localparam int BTN_P1_UP   = 3;

  localparam int CLK_HZ = 25_000_000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYCLES = ms_to_cycles(10);   // 250_000
  localparam int REPEAT_DELAY    = ms_to_cycles(250);  // 6_250_000
  localparam int REPEAT_PERIOD   = ms_to_cycles(100);  // 2_500_000

  typedef logic [NUM_BTNS-1:0] btn_vec_t;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus between the raw pads and the game core: raw pins in,
// debounced level and press/release strobes out.
interface btn_conditioner_if #(
  parameter int NUM_BTNS = 4
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_release;

  // master drives the pads and consumes the conditioned outputs.
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, stability counter, debounced level and
// registered press/release strobes. Auto-repeat is built only with BTN_AUTOREPEAT_EN.
module btn_debounce_ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int REPEAT_DELAY    = 6_250_000,
  parameter int REPEAT_PERIOD   = 2_500_000
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("btn_debounce_ch: SYNC_STAGES must be 2 or 3");
  end
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_timing
    $error("btn_debounce_ch: DEBOUNCE_CYCLES and REPEAT_* must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;
  logic                   rep_fire;

  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = (s != level) && (cnt == CNT_LAST);

  // NOTE: every flop, including the synchroniser, is in the async reset so
  // a reset mid-debounce leaves no partial count or stale sample behind.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // NOTE: non-blocking assignments throughout, so cnt, level and the strobes
  // all see the same pre-edge value of s and cnt.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      if (s == level || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (accept) begin
        level <= s;
      end
      press <= (accept & s) | rep_fire;
      rel   <= accept & ~s;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_periodic;
  logic [REP_W-1:0] rep_limit;

  // The hold counter reloads at each repeat, so it never exceeds its limit.
  assign rep_limit = rep_periodic ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
  assign rep_fire  = level & ~accept & (rep_cnt == rep_limit);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt      <= '0;
      rep_periodic <= 1'b0;
    end else if (accept) begin
      rep_cnt      <= '0;
      rep_periodic <= 1'b0;
    end else if (level) begin
      if (rep_fire) begin
        rep_cnt      <= '0;
        rep_periodic <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Conditions NUM_BTNS raw player buttons into debounced levels and strobes
// for the game core. Optional auto-repeat on btn_press: define BTN_AUTOREPEAT_EN.
module btn_conditioner #(
  parameter int NUM_BTNS        = shady_pong_pkg::NUM_BTNS,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = shady_pong_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = shady_pong_pkg::REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = shady_pong_pkg::REPEAT_PERIOD
) (
  input  logic               CLK,
  input  logic               rst_n,
  btn_conditioner_if.slave   bus
);

  logic [NUM_BTNS-1:0] level_v;
  logic [NUM_BTNS-1:0] press_v;
  logic [NUM_BTNS-1:0] rel_v;

  // Channels are independent; simultaneous changes resolve on the same edge.
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .CLK   (CLK),
      .rst_n (rst_n),
      .raw   (bus.btn_raw[i]),
      .level (level_v[i]),
      .press (press_v[i]),
      .rel   (rel_v[i])
    );
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = rel_v;

endmodule
